// File: rtl/sb_cfg_loader.sv
// rtl/sb_cfg_loader.sv - serial switch-box select loader with pair check and atomic commit
// Optional readback of the committed word: define SB_READBACK_EN.
module sb_cfg_loader #(
    parameter int SEL_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_bit,
    input  logic             cfg_last,
    output logic [SEL_W-1:0] sel,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [1:0]       err_code
`ifdef SB_READBACK_EN
    ,
    input  logic             rb_req,
    output logic             rb_bit,
    output logic             rb_valid,
    output logic             rb_last
`endif
);

    localparam int CNT_W = $clog2(SEL_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SEL_W);

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_SHORT = 2'b01;
    localparam logic [1:0] E_LONG  = 2'b10;
    localparam logic [1:0] E_PAIR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_CHECK
`ifdef SB_READBACK_EN
        ,
        S_READBACK
`endif
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_shadow;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_count;
    logic               r_ready;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_code;
`ifdef SB_READBACK_EN
    logic               r_rb_bit;
    logic               r_rb_valid;
    logic               r_rb_last;
`endif

    logic               w_beat;
    logic [CNT_W-1:0]   w_count_nx;
    logic [SEL_W-1:0]   w_shadow_nx;
    logic               w_illegal;

    assign w_beat      = cfg_valid & r_ready;
    assign w_count_nx  = r_count + 1'b1;
    assign w_shadow_nx = {cfg_bit, r_shadow[SEL_W-1:1]};

    always_comb begin
        w_illegal = 1'b0;
        for (int i = 0; i < SEL_W / 2; i++) begin
            if (r_shadow[2*i +: 2] == 2'b11) w_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_sel    <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_code   <= E_NONE;
`ifdef SB_READBACK_EN
            r_rb_bit   <= 1'b0;
            r_rb_valid <= 1'b0;
            r_rb_last  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_beat) begin
                        r_shadow <= w_shadow_nx;
                        r_err    <= 1'b0;
                        r_code   <= E_NONE;
                        if (cfg_last) begin
                            r_err   <= 1'b1;
                            r_code  <= E_SHORT;
                            r_count <= '0;
                        end else begin
                            r_count <= 1;
                            r_state <= S_SHIFT;
                        end
                    end
`ifdef SB_READBACK_EN
                    else if (rb_req) begin
                        // shadow is idle here, so it doubles as the readback shifter
                        r_state    <= S_READBACK;
                        r_ready    <= 1'b0;
                        r_shadow   <= r_sel >> 1;
                        r_rb_bit   <= r_sel[0];
                        r_rb_valid <= 1'b1;
                        r_rb_last  <= 1'b0;
                        r_count    <= 1;
                    end
`endif
                end
                S_SHIFT: begin
                    if (w_beat) begin
                        r_shadow <= w_shadow_nx;
                        r_count  <= w_count_nx;
                        if (w_count_nx == FULL) begin
                            if (cfg_last) begin
                                r_state <= S_CHECK;
                                r_ready <= 1'b0;
                            end else begin
                                r_err   <= 1'b1;
                                r_code  <= E_LONG;
                                r_state <= S_DRAIN;
                            end
                        end else if (cfg_last) begin
                            r_err   <= 1'b1;
                            r_code  <= E_SHORT;
                            r_count <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_beat && cfg_last) begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_err  <= 1'b1;
                        r_code <= E_PAIR;
                    end else begin
                        r_sel  <= r_shadow;
                        r_done <= 1'b1;
                    end
                    r_count <= '0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
`ifdef SB_READBACK_EN
                S_READBACK: begin
                    if (r_count == FULL) begin
                        r_rb_valid <= 1'b0;
                        r_rb_last  <= 1'b0;
                        r_count    <= '0;
                        r_ready    <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_rb_bit  <= r_shadow[0];
                        r_shadow  <= r_shadow >> 1;
                        r_rb_last <= (w_count_nx == FULL);
                        r_count   <= w_count_nx;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign sel       = r_sel;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign err_code  = r_code;
`ifdef SB_READBACK_EN
    assign rb_bit    = r_rb_bit;
    assign rb_valid  = r_rb_valid;
    assign rb_last   = r_rb_last;
`endif

endmodule
